// File: rtl/spmv_pe_stream_ctrl.sv
// SpMV processing-element control core: op-bus decode and forwarding, argument registers,
// credit-limited streaming of memory load requests and the busy chain.
module spmv_pe_stream_ctrl #(
  parameter int unsigned ID           = 0,
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned ADDR_WIDTH   = 48,
  parameter int unsigned STRIDE       = 8,
  parameter int unsigned MAX_OUTSTAND = 8,
  parameter int unsigned TAG_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           op_in,
  output logic [63:0]           op_out,
  input  logic                  busy_in,
  output logic                  busy_out,
  output logic                  req_mem_ld,
  output logic [ADDR_WIDTH-1:0] req_mem_addr,
  output logic [TAG_WIDTH-1:0]  req_mem_tag,
  input  logic                  req_mem_stall,
  input  logic                  rsp_mem_push,
  input  logic [63:0]           rsp_mem_q,
  output logic                  rsp_mem_stall,
  output logic                  dec_push,
  output logic [63:0]           dec_q,
  input  logic                  dec_stall
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTAND) + 1;
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTAND);
  localparam logic [6:0] OpRst    = 7'd1;
  localparam logic [6:0] OpSteady = 7'd2;
  localparam logic [6:0] OpLd     = 7'd3;

  typedef enum logic [1:0] {StIdle, StSteady, StDrain} state_e;

  state_e                state;
  logic [63:0]           op_q;
  logic [ADDR_WIDTH-1:0] regs [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag;
  logic [CntW-1:0]       outstanding;
  logic [CntW-1:0]       outstanding_d;

  logic                  op_acc;
  logic [3:0]            op_idx;
  logic [ADDR_WIDTH-1:0] op_data;
  logic                  rst_op;
  logic                  steady_op;
  logic                  ld_op;
  logic                  ld_r0;
  logic                  addr_lt;
  logic                  issue;
  logic                  rsp_dec;
  logic                  local_busy;

  assign op_acc    = op_q[11] | (op_q[10:7] == 4'(ID));
  assign op_idx    = op_q[15:12];
  assign op_data   = op_q[16 +: ADDR_WIDTH];
  assign rst_op    = op_acc & (op_q[6:0] == OpRst);
  assign steady_op = op_acc & (op_q[6:0] == OpSteady);
  assign ld_op     = op_acc & (op_q[6:0] == OpLd);
  assign ld_r0     = ld_op & (op_idx == 4'd0);

  assign addr_lt = regs[0] < regs[1];
  // A reg0 load in the same cycle would make the issued address stale, so it blocks issue.
  assign issue   = (state == StSteady) & addr_lt & ~req_mem_stall & (outstanding < MaxOut)
                 & ~ld_r0;
  // Responses arriving after a reset has cleared the count must not underflow it.
  assign rsp_dec = rsp_mem_push & (outstanding != '0);

  always_comb begin
    outstanding_d = outstanding;
    if (issue && !rsp_dec) begin
      outstanding_d = outstanding + CntW'(1);
    end else if (!issue && rsp_dec) begin
      outstanding_d = outstanding - CntW'(1);
    end
  end

  assign local_busy = (state != StIdle) | (outstanding != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      busy_out    <= 1'b0;
      tag         <= '0;
      outstanding <= '0;
      state       <= StIdle;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      op_q        <= op_in;
      busy_out    <= busy_in | local_busy;
      outstanding <= outstanding_d;
      if (rst_op) begin
        tag   <= '0;
        state <= (outstanding_d != '0) ? StDrain : StIdle;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          regs[i] <= '0;
        end
      end else begin
        if (issue) begin
          regs[0] <= regs[0] + ADDR_WIDTH'(STRIDE);
          tag     <= tag + TAG_WIDTH'(1);
        end
        // Placed after the increment so an explicit load of reg0 wins.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (ld_op && (op_idx == 4'(i))) begin
            regs[i] <= op_data;
          end
        end
        unique case (state)
          StIdle: begin
            if (steady_op) state <= StSteady;
          end
          StSteady: begin
            if (!addr_lt) state <= StDrain;
          end
          StDrain: begin
            if (steady_op) begin
              state <= StSteady;
            end else if (outstanding == '0) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign op_out        = op_q;
  assign req_mem_ld    = issue;
  assign req_mem_addr  = regs[0];
  assign req_mem_tag   = tag;
  assign rsp_mem_stall = dec_stall;
  assign dec_push      = rsp_mem_push;
  assign dec_q         = rsp_mem_q;

endmodule
